// File: rtl/b1_obs_framer_if.sv
// Byte stream from the observation framer to the UART transmitter.
interface b1_obs_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rx_ready;

    modport master (output tx_data, output tx_valid, input rx_ready);
    modport slave  (input tx_data, input tx_valid, output rx_ready);
endinterface

// File: rtl/b1_obs_framer.sv
// Snapshots both tracking channels on PPS and streams them as a 36-byte
// sync-headed, checksummed record over a valid/ready byte interface.
module b1_obs_framer (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic                  rx_en,
    input  logic                  rx_pps,
    input  logic [31:0]           rx_boc_car_nco,
    input  logic [31:0]           rx_boc_prn_nco,
    input  logic [11:0]           rx_boc_prn_phs,
    input  logic [23:0]           rx_bbP_real,
    input  logic [23:0]           rx_bbP_imag,
    input  logic [31:0]           rx_tmboc_car_nco,
    input  logic [31:0]           rx_tmboc_prn_nco,
    input  logic [11:0]           rx_tmboc_prn_phs,
    input  logic [23:0]           rx_tmboc_bbP_real,
    input  logic [23:0]           rx_tmboc_bbP_imag,
    b1_obs_framer_if.master       bus,
    output logic                  tx_busy,
    output logic [7:0]            tx_ovf_cnt
);
    localparam logic [7:0]  HDR0      = 8'hEB;
    localparam logic [7:0]  HDR1      = 8'h90;
    localparam int unsigned FRAME_LEN = 36;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned PAY_W     = 264;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] CSUM_END = IDX_W'(FRAME_LEN - 2);

    typedef struct packed {
        logic [31:0] boc_car;
        logic [31:0] boc_prn;
        logic [11:0] boc_phs;
        logic [23:0] boc_re;
        logic [23:0] boc_im;
        logic [31:0] tm_car;
        logic [31:0] tm_prn;
        logic [11:0] tm_phs;
        logic [23:0] tm_re;
        logic [23:0] tm_im;
    } bank_t;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    bank_t            bank;
    logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
    logic [7:0]       seq, seq_nxt, csum, csum_nxt, ovf_nxt, data_nxt, pay_byte;
    logic             valid_nxt, busy_nxt, load;
    logic             arm, xfer, last;
    logic [PAY_W-1:0] payload;
    logic [8:0]       sh;

    assign arm     = rx_pps && rx_en;
    assign xfer    = bus.tx_valid && bus.rx_ready;
    assign last    = xfer && (idx == LAST_IDX);
    assign idx_inc = idx + IDX_W'(1);

    // Bytes 2..34 of the frame, MSB first; seq is stable for the whole frame
    assign payload = {seq, bank.boc_car, bank.boc_prn, 4'b0, bank.boc_phs,
                      bank.boc_re, bank.boc_im, bank.tm_car, bank.tm_prn,
                      4'b0, bank.tm_phs, bank.tm_re, bank.tm_im};
    assign sh       = {6'(CSUM_END - idx_inc), 3'b000};
    assign pay_byte = 8'(payload >> sh);

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm)  state_nxt = SEND;
            SEND:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_nxt  = bus.tx_data;
        valid_nxt = bus.tx_valid;
        busy_nxt  = tx_busy;
        idx_nxt   = idx;
        seq_nxt   = seq;
        csum_nxt  = csum;
        ovf_nxt   = tx_ovf_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    load      = 1'b1;
                    data_nxt  = HDR0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                if (arm && (tx_ovf_cnt != 8'hFF)) ovf_nxt = tx_ovf_cnt + 8'd1;
                if (xfer) begin
                    if ((idx >= IDX_W'(2)) && (idx <= CSUM_END))
                        csum_nxt = csum + bus.tx_data;
                    if (last) begin
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        seq_nxt   = seq + 8'd1;
                        csum_nxt  = '0;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx_inc;
                        // Checksum byte folds in byte 34, which is transferring now
                        if (idx_inc == IDX_W'(1))   data_nxt = HDR1;
                        else if (idx_inc == LAST_IDX) data_nxt = csum + bus.tx_data;
                        else                        data_nxt = pay_byte;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            tx_busy      <= 1'b0;
            tx_ovf_cnt   <= '0;
            idx          <= '0;
            seq          <= '0;
            csum         <= '0;
            bank         <= '0;
        end else begin
            bus.tx_data  <= data_nxt;
            bus.tx_valid <= valid_nxt;
            tx_busy      <= busy_nxt;
            tx_ovf_cnt   <= ovf_nxt;
            idx          <= idx_nxt;
            seq          <= seq_nxt;
            csum         <= csum_nxt;
            if (load)
                bank <= {rx_boc_car_nco, rx_boc_prn_nco, rx_boc_prn_phs,
                         rx_bbP_real, rx_bbP_imag, rx_tmboc_car_nco,
                         rx_tmboc_prn_nco, rx_tmboc_prn_phs,
                         rx_tmboc_bbP_real, rx_tmboc_bbP_imag};
        end
    end
endmodule

// File: tb/tb_b1_obs_framer.sv
// Scoreboard bench for b1_obs_framer: expected frames are queued at PPS time
// and compared byte by byte as the DUT presents them.
module tb_b1_obs_framer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, pps = 1'b0;
    logic [31:0] boc_car = '0, boc_prn = '0, tm_car = '0, tm_prn = '0;
    logic [11:0] boc_phs = '0, tm_phs = '0;
    logic [23:0] boc_re = '0, boc_im = '0, tm_re = '0, tm_im = '0;
    logic        tx_busy;
    logic [7:0]  tx_ovf_cnt;
    logic        tog = 1'b0;

    logic [7:0]  sb[$];
    logic [7:0]  got [0:35];
    int          rx_idx = 0;
    int          mseq = 0;
    logic [7:0]  last_sum;
    int          n_cmp = 0, n_err = 0;
    int          n;

    b1_obs_framer_if bus ();

    b1_obs_framer dut (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en), .rx_pps(pps),
        .rx_boc_car_nco(boc_car), .rx_boc_prn_nco(boc_prn), .rx_boc_prn_phs(boc_phs),
        .rx_bbP_real(boc_re), .rx_bbP_imag(boc_im),
        .rx_tmboc_car_nco(tm_car), .rx_tmboc_prn_nco(tm_prn), .rx_tmboc_prn_phs(tm_phs),
        .rx_tmboc_bbP_real(tm_re), .rx_tmboc_bbP_imag(tm_im),
        .bus(bus), .tx_busy(tx_busy), .tx_ovf_cnt(tx_ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        logic [263:0] p;
        logic [7:0]   b, sum;
        p = {8'(mseq), boc_car, boc_prn, 4'b0, boc_phs, boc_re, boc_im,
             tm_car, tm_prn, 4'b0, tm_phs, tm_re, tm_im};
        sb.push_back(8'hEB);
        sb.push_back(8'h90);
        sum = '0;
        for (int k = 0; k < 33; k++) begin
            b = p[263 - 8*k -: 8];
            sum = sum + b;
            sb.push_back(b);
        end
        sb.push_back(sum);
        last_sum = sum;
        mseq = (mseq + 1) % 256;
    endtask

    // Called at posedge+1; the pulse is seen by the following edge
    task automatic send_pps(input bit expect_frame);
        pps = 1'b1;
        if (expect_frame) push_frame();
        @(posedge clk); #1;
        pps = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output int cnt);
        cnt = 0;
        while (sb.size() != 0 && cnt < budget) begin
            @(negedge clk); #1;
            cnt++;
        end
        check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        check_eq("idle_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("idle_busy", 32'(tx_busy), 32'd0);
    endtask

    task automatic zero_inputs();
        boc_car = '0; boc_prn = '0; boc_phs = '0; boc_re = '0; boc_im = '0;
        tm_car = '0; tm_prn = '0; tm_phs = '0; tm_re = '0; tm_im = '0;
    endtask

    // Every presented byte is compared; a stalled byte must equal the queue head
    always @(negedge clk) begin
        if (rst_n && bus.tx_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'(bus.tx_valid), 32'd0);
            end else begin
                check_eq($sformatf("byte%0d", rx_idx), 32'(bus.tx_data), 32'(sb[0]));
                if (bus.rx_ready) begin
                    got[rx_idx] = bus.tx_data;
                    void'(sb.pop_front());
                    rx_idx = (rx_idx == 35) ? 0 : rx_idx + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (tog) bus.rx_ready = ~bus.rx_ready;
    end

    initial begin
        bus.rx_ready = 1'b1;
        #1;
        check_eq("rst_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("rst_data", 32'(bus.tx_data), 32'd0);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_ovf", 32'(tx_ovf_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; en = 1'b1;
        @(posedge clk); #1;

        // Basic frame; inputs changed mid-frame must not leak into the output
        boc_car = 32'h11223344;
        send_pps(1'b1);
        check_eq("t1_busy", 32'(tx_busy), 32'd1);
        boc_car = 32'hDEADBEEF;
        wait_drain(200, n);
        check_eq("t1_len", 32'(n), 32'd36);
        check_eq("t1_b3", 32'(got[3]), 32'h11);
        check_eq("t1_b6", 32'(got[6]), 32'h44);
        check_eq("t1_cksum", 32'(got[35]), 32'hAA);

        // Ready toggling every cycle
        boc_car = 32'h11223344;
        send_pps(1'b1);
        bus.rx_ready = 1'b0;
        tog = 1'b1;
        wait_drain(200, n);
        tog = 1'b0;
        bus.rx_ready = 1'b1;
        check_eq("t2_len", 32'(n), 32'd71);

        // Sign bit / phase edge values
        zero_inputs();
        boc_re = 24'h800001; tm_phs = 12'hFFF; boc_im = 24'h00ABCD; tm_prn = 32'hCAFEF00D;
        send_pps(1'b1);
        wait_drain(200, n);
        check_eq("t6_b13", 32'(got[13]), 32'h80);
        check_eq("t6_b14", 32'(got[14]), 32'h00);
        check_eq("t6_b15", 32'(got[15]), 32'h01);
        check_eq("t6_b27", 32'(got[27]), 32'h0F);
        check_eq("t6_b28", 32'(got[28]), 32'hFF);
        check_eq("t6_cksum", 32'(got[35]), 32'(last_sum));

        // Dropped PPS mid-frame, then saturation of the drop counter
        send_pps(1'b1);
        n = 0;
        while (sb.size() > 26 && n < 100) begin @(posedge clk); #1; n++; end
        send_pps(1'b0);
        wait_drain(200, n);
        check_eq("t3_ovf1", 32'(tx_ovf_cnt), 32'd1);
        send_pps(1'b1);
        bus.rx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_pps(1'b0);
            @(posedge clk); #1;
        end
        bus.rx_ready = 1'b1;
        wait_drain(200, n);
        check_eq("t3_ovf_sat", 32'(tx_ovf_cnt), 32'd255);

        // Async reset partway through a frame
        send_pps(1'b1);
        n = 0;
        while (sb.size() > 16 && n < 100) begin @(posedge clk); #1; n++; end
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("t5_busy", 32'(tx_busy), 32'd0);
        check_eq("t5_ovf", 32'(tx_ovf_cnt), 32'd0);
        sb.delete();
        rx_idx = 0;
        mseq = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_pps(1'b1);
        wait_drain(200, n);
        check_eq("t5_hdr", 32'(got[0]), 32'hEB);
        check_eq("t5_seq", 32'(got[2]), 32'h00);

        // Sequence counter wrap across 256 frames
        for (int i = 1; i < 256; i++) begin
            boc_prn = 32'($urandom);
            tm_im   = 24'($urandom);
            send_pps(1'b1);
            wait_drain(200, n);
        end
        check_eq("t4_seq_ff", 32'(got[2]), 32'hFF);
        send_pps(1'b1);
        wait_drain(200, n);
        check_eq("t4_seq_wrap", 32'(got[2]), 32'h00);

        // Disabled: PPS ignored
        en = 1'b0;
        send_pps(1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("t4_dis_valid", 32'(bus.tx_valid), 32'd0);
        end
        check_eq("t4_dis_ovf", 32'(tx_ovf_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
